// File: rtl/branch_history_table_pkg.sv
// Shared frontend types for the branch history table: resolved-branch
// record from the branch unit, the prediction returned to pc generation,
// the control-flow classification and the flush engine states.
package branch_history_table_pkg;

    // Default table depth used when instantiating the BHT
    localparam int unsigned BHT_ENTRIES = 1024;

    // Control-flow classification of a resolved instruction
    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    // Resolved branch as produced by the execute-stage branch unit
    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        cf_t         cf_type;
    } branchpredict_t;

    // Direction prediction handed back to pc generation
    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    // Flush engine states
    typedef enum logic {
        BHT_IDLE  = 1'b0,
        BHT_FLUSH = 1'b1
    } bht_state_e;

endpackage

// File: rtl/branch_history_table_sat_counter.sv
// Combinational next-state for one BHT entry {valid, cnt}. A fresh entry
// starts weakly biased toward the observed outcome; a live entry moves one
// step toward it and saturates at the strong ends.
module bht_sat_counter (
    input  logic       valid_i,
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic       valid_o,
    output logic [1:0] cnt_o
);

    // Next {valid, cnt} after observing one resolved branch
    always_comb begin
        valid_o = 1'b1;
        cnt_o   = cnt_i;
        if (!valid_i) begin
            cnt_o = taken_i ? 2'b10 : 2'b01;
        end else if (taken_i) begin
            cnt_o = (cnt_i == 2'b11) ? 2'b11 : cnt_i + 2'b01;
        end else begin
            cnt_o = (cnt_i == 2'b00) ? 2'b00 : cnt_i - 2'b01;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Branch history table: per-PC 2-bit saturating direction predictor with a
// registered lookup port, a training port fed by resolved branches, and a
// sequential flush engine that clears one entry per cycle.
module branch_history_table
    import branch_history_table_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = BHT_ENTRIES
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic            vpc_valid_i,
    input  logic [63:0]     vpc_i,
    input  branchpredict_t  bht_update_i,
    output bht_prediction_t bht_prediction_o,
    output logic            busy_o
);

    localparam int unsigned INDEX_BITS = $clog2(NR_ENTRIES);

    // Table storage
    logic [NR_ENTRIES-1:0] valid_q;
    logic [1:0]            cnt_q [NR_ENTRIES];

    // Flush engine
    bht_state_e            state_q, state_d;
    logic [INDEX_BITS-1:0] flush_idx_q, flush_idx_d;

    // Registered prediction
    bht_prediction_t       pred_q, pred_d;

    // PCs are 2-byte aligned (compressed instructions), so bit 0 carries no index information
    logic [INDEX_BITS-1:0] update_idx;
    logic [INDEX_BITS-1:0] lookup_idx;
    assign update_idx = bht_update_i.pc[INDEX_BITS:1];
    assign lookup_idx = vpc_i[INDEX_BITS:1];

    // The table is only serviced while idle and not being told to flush this cycle
    logic serviceable;
    logic train_en;
    logic lookup_en;
    assign serviceable = (state_q == BHT_IDLE) && !flush_i;
    assign train_en    = serviceable && bht_update_i.valid && !debug_mode_i
                         && (bht_update_i.cf_type == Branch);
    assign lookup_en   = serviceable && vpc_valid_i;

    // Post-update value of the trained entry, used for the write and for forwarding
    logic       upd_valid;
    logic [1:0] upd_cnt;

    bht_sat_counter i_sat_counter (
        .valid_i (valid_q[update_idx]),
        .cnt_i   (cnt_q[update_idx]),
        .taken_i (bht_update_i.is_taken),
        .valid_o (upd_valid),
        .cnt_o   (upd_cnt)
    );

    // Target address, mispredict flag and the PC bits above the index do not affect prediction
    logic unused_bits;
    assign unused_bits = ^{vpc_i[63:INDEX_BITS+1], vpc_i[0],
                           bht_update_i.pc[63:INDEX_BITS+1], bht_update_i.pc[0],
                           bht_update_i.target_address, bht_update_i.is_mispredict};

    // Lookup read with same-index forwarding so the answer matches next cycle's table contents
    always_comb begin
        logic       rd_valid;
        logic [1:0] rd_cnt;
        rd_valid = valid_q[lookup_idx];
        rd_cnt   = cnt_q[lookup_idx];
        if (train_en && (update_idx == lookup_idx)) begin
            rd_valid = upd_valid;
            rd_cnt   = upd_cnt;
        end
        pred_d       = '0;
        pred_d.valid = lookup_en && rd_valid;
        pred_d.taken = lookup_en && rd_cnt[1];
    end

    // Flush engine next-state: walk every index once, restart on a new flush request
    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        unique case (state_q)
            BHT_IDLE: begin
                if (flush_i) begin
                    state_d     = BHT_FLUSH;
                    flush_idx_d = '0;
                end
            end
            BHT_FLUSH: begin
                if (flush_i) begin
                    flush_idx_d = '0;
                end else if (flush_idx_q == INDEX_BITS'(NR_ENTRIES - 1)) begin
                    state_d     = BHT_IDLE;
                    flush_idx_d = '0;
                end else begin
                    flush_idx_d = flush_idx_q + INDEX_BITS'(1);
                end
            end
            default: begin
                state_d     = BHT_IDLE;
                flush_idx_d = '0;
            end
        endcase
    end

    // Flush engine and prediction registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= BHT_IDLE;
            flush_idx_q <= '0;
            pred_q      <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            pred_q      <= pred_d;
        end
    end

    // Table write: flushing clears one entry per cycle, otherwise apply training
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                cnt_q[i] <= 2'b00;
            end
        end else if (state_q == BHT_FLUSH) begin
            valid_q[flush_idx_q] <= 1'b0;
            cnt_q[flush_idx_q]   <= 2'b00;
        end else if (train_en) begin
            valid_q[update_idx] <= upd_valid;
            cnt_q[update_idx]   <= upd_cnt;
        end
    end

    assign bht_prediction_o = pred_q;
    assign busy_o           = (state_q == BHT_FLUSH);

endmodule
